// File: rtl/router_pkg.sv
// router_pkg
// Shared constants, the packet-source state type and the header-byte helper
// for the 3-port router packet source.
package router_pkg;

  localparam int ADDR_W    = 2;
  localparam int LEN_W     = 6;
  localparam int DATA_W    = 8;
  localparam int NUM_PORTS = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    PLD,
    PAR,
    GAP
  } src_state_t;

  // Router header: length in the upper six bits, destination port in the lower two.
  function automatic logic [DATA_W-1:0] hdr_byte(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_src_buf.sv
// router_src_buf
// Payload store for the packet source: 64 x 8 register array, one synchronous
// write port and one combinational read port. Contents are not reset; the
// write pointer in the parent decides what is valid.
//
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write index (0..63)
//   wr_data  in   byte to store
//   rd_addr  in   read index (0..63)
//   rd_data  out  byte at rd_addr, combinational
module router_src_buf
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LEN_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [LEN_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << LEN_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/router_pkt_source.sv
// router_pkt_source
// Upstream packet injector for the 3-port router. Accepts a host request
// (destination, length), buffers the whole payload, then streams header,
// payload and parity byte to the router without gaps, honouring busy and
// leaving at least IFG idle cycles before the next header.
//
// Optional build macro ROUTER_SRC_ERR_CNT_EN adds err_cnt, a saturating count
// of rising edges on the router's err flag. Without it, err is unused.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   host request strobe
//   req_ready  out  request can be accepted (IDLE and not in reset)
//   req_addr   in   destination port 0..2
//   req_len    in   payload length 1..MAX_LEN
//   req_err    out  one-cycle pulse: request rejected
//   pl_valid   in   payload byte valid
//   pl_ready   out  payload byte accepted on pl_valid & pl_ready
//   pl_data    in   payload byte
//   pkt_valid  out  packet valid to router (low during parity byte)
//   pkt_data   out  byte to router d_in
//   busy       in   router busy: outputs hold while high
//   err        in   router parity-error flag
//   tx_done    out  one-cycle pulse after the parity byte is consumed
//   err_cnt    out  [7:0] saturating err edge count (ROUTER_SRC_ERR_CNT_EN only)
module router_pkt_source
  import router_pkg::*;
#(
  parameter int MAX_LEN = 63,
  parameter int IFG     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  output logic              req_err,
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [DATA_W-1:0] pl_data,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] pkt_data,
  input  logic              busy,
  input  logic              err,
  output logic              tx_done
`ifdef ROUTER_SRC_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int                GAP_W     = (IFG < 2) ? 1 : $clog2(IFG + 1);
  localparam logic [LEN_W:0]    MAX_LEN_X = (LEN_W + 1)'(MAX_LEN);
  localparam logic [ADDR_W-1:0] BAD_ADDR  = ADDR_W'(NUM_PORTS);

  src_state_t        state, state_nxt;
  logic [LEN_W-1:0]  wr_ptr, wr_ptr_nxt;
  logic [LEN_W-1:0]  rd_ptr, rd_ptr_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_nxt;
  logic              pkt_valid_nxt;
  logic [DATA_W-1:0] pkt_data_nxt;
  logic              req_err_nxt, tx_done_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] parity, parity_nxt;

  logic              buf_we;
  logic [LEN_W-1:0]  rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              consume;

  router_src_buf u_buf (
    .clk     (clk),
    .wr_en   (buf_we),
    .wr_addr (wr_ptr),
    .wr_data (pl_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign req_ready = (state == IDLE) && !rst;
  assign pl_ready  = (state == LOAD) && (wr_ptr < len_q);
  assign consume   = !busy;
  // In HDR the first payload byte is fetched; in PLD the next one.
  assign rd_addr   = (state == PLD) ? rd_ptr : '0;

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    rd_ptr_nxt    = rd_ptr;
    gap_nxt       = gap_cnt;
    pkt_valid_nxt = pkt_valid;
    pkt_data_nxt  = pkt_data;
    req_err_nxt   = 1'b0;
    tx_done_nxt   = 1'b0;
    len_nxt       = len_q;
    addr_nxt      = addr_q;
    parity_nxt    = parity;
    buf_we        = 1'b0;

    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_addr == BAD_ADDR || req_len == '0 || {1'b0, req_len} > MAX_LEN_X) begin
            req_err_nxt = 1'b1;
          end else begin
            len_nxt    = req_len;
            addr_nxt   = req_addr;
            wr_ptr_nxt = '0;
            state_nxt  = LOAD;
          end
        end
      end

      LOAD: begin
        if (pl_valid && pl_ready) begin
          buf_we     = 1'b1;
          wr_ptr_nxt = wr_ptr + LEN_W'(1);
          // Last payload byte: the header goes out on the very next cycle.
          if (wr_ptr == len_q - LEN_W'(1)) begin
            pkt_data_nxt  = hdr_byte(len_q, addr_q);
            pkt_valid_nxt = 1'b1;
            parity_nxt    = hdr_byte(len_q, addr_q);
            state_nxt     = HDR;
          end
        end
      end

      HDR: begin
        if (consume) begin
          pkt_data_nxt = rd_data;
          rd_ptr_nxt   = LEN_W'(1);
          state_nxt    = PLD;
        end
      end

      PLD: begin
        if (consume) begin
          parity_nxt = parity ^ pkt_data;
          // rd_ptr == len means the byte just consumed was the last payload byte.
          if (rd_ptr == len_q) begin
            pkt_data_nxt  = parity ^ pkt_data;
            pkt_valid_nxt = 1'b0;
            state_nxt     = PAR;
          end else begin
            pkt_data_nxt = rd_data;
            rd_ptr_nxt   = rd_ptr + LEN_W'(1);
          end
        end
      end

      PAR: begin
        if (consume) begin
          tx_done_nxt  = 1'b1;
          pkt_data_nxt = '0;
          gap_nxt      = GAP_W'(IFG);
          state_nxt    = GAP;
        end
      end

      GAP: begin
        if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - GAP_W'(1);
        end else if (!busy) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      gap_cnt   <= '0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      req_err   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      gap_cnt   <= gap_nxt;
      pkt_valid <= pkt_valid_nxt;
      pkt_data  <= pkt_data_nxt;
      req_err   <= req_err_nxt;
      tx_done   <= tx_done_nxt;
    end
  end

  // Request fields and running parity are only meaningful once the FSM has
  // left IDLE, so they carry no reset.
  always_ff @(posedge clk) begin
    len_q  <= len_nxt;
    addr_q <= addr_nxt;
    parity <= parity_nxt;
  end

`ifdef ROUTER_SRC_ERR_CNT_EN
  logic err_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q <= err;
      if (err && !err_q) err_cnt <= sat_inc(err_cnt);
    end
  end
`else
  logic unused_err;
  assign unused_err = err;
`endif

endmodule
